// File: rtl/zv_prefix_sum_pipe.sv
`default_nettype none
// ============================================================================
// Module      : zv_prefix_sum_pipe
// Description : Pipelined Ladner-Fischer prefix-sum unit for lane bitmasks.
//               Produces per-lane compaction (bubble) indices plus the
//               popcount of the mask, with one prefix level per pipe stage.
// Ports       : clk, reset (async, active-high), flush (sync discard),
//               in_valid/in_ready/in_mask/in_excl  - input vector handshake
//               out_valid/out_ready/out_psum/out_total - result handshake
//               out_psum lane i sits at [i*IDX_WIDTH +: IDX_WIDTH].
// Config      : ZVPS_OUT_REG_EN - when defined, adds a flopped output stage
//               after the exclusive adjust/total (latency LOG2_LINE+1).
// Revision    : 1.0 - initial release
// ============================================================================
module zv_prefix_sum_pipe #(
    parameter int LINE_SIZE = 32,
    parameter int LOG2_LINE = $clog2(LINE_SIZE),
    parameter int IDX_WIDTH = $clog2(LINE_SIZE) + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LINE_SIZE-1:0]           in_mask,
    input  logic                           in_excl,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LINE_SIZE*IDX_WIDTH-1:0] out_psum,
    output logic [IDX_WIDTH-1:0]           out_total
);

    // w_stage[0] is the zero-extended mask; w_stage[k+1] is stage k's register.
    logic [IDX_WIDTH-1:0] w_stage [LOG2_LINE+1][LINE_SIZE];
    logic [IDX_WIDTH-1:0] w_next  [LOG2_LINE][LINE_SIZE];
    logic [IDX_WIDTH-1:0] r_sum   [LOG2_LINE][LINE_SIZE];
    logic [LOG2_LINE-1:0] r_vld;
    logic [LOG2_LINE-1:0] r_excl;
    logic [LOG2_LINE:0]   w_vld;
    logic [LOG2_LINE:0]   w_excl;
    logic                 w_advance;

    logic [IDX_WIDTH-1:0]           w_out_lane [LINE_SIZE];
    logic [LINE_SIZE*IDX_WIDTH-1:0] w_psum;
    logic [IDX_WIDTH-1:0]           w_total;

    // Whole pipe (bubbles included) freezes only when the head result is refused.
    assign w_advance = !(out_valid && !out_ready);
    assign in_ready  = w_advance && !flush;

    assign w_vld  = {r_vld, in_valid};
    assign w_excl = {r_excl, in_excl};

    generate
        for (genvar j = 0; j < LINE_SIZE; j++) begin : g_lane_in
            assign w_stage[0][j] = IDX_WIDTH'(in_mask[j]);
        end

        for (genvar k = 0; k < LOG2_LINE; k++) begin : g_level
            for (genvar j = 0; j < LINE_SIZE; j++) begin : g_lane
                assign w_stage[k+1][j] = r_sum[k][j];
                if (((j >> k) & 1) == 1) begin : g_add
                    // Last lane of the lower half of this 2^(k+1) block.
                    localparam int c_SRC = ((j >> (k + 1)) << (k + 1)) + (1 << k) - 1;
                    assign w_next[k][j] = w_stage[k][j] + w_stage[k][c_SRC];
                end else begin : g_pass
                    assign w_next[k][j] = w_stage[k][j];
                end
            end
        end

        // Exclusive lane i equals inclusive lane i-1, so the mask need not travel.
        for (genvar j = 0; j < LINE_SIZE; j++) begin : g_out_lane
            if (j == 0) begin : g_first
                assign w_out_lane[j] = w_excl[LOG2_LINE] ? '0 : w_stage[LOG2_LINE][j];
            end else begin : g_rest
                assign w_out_lane[j] = w_excl[LOG2_LINE] ? w_stage[LOG2_LINE][j-1]
                                                         : w_stage[LOG2_LINE][j];
            end
        end
    endgenerate

    always_comb begin
        w_psum = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            w_psum[i*IDX_WIDTH +: IDX_WIDTH] = w_out_lane[i];
        end
    end

    assign w_total = w_stage[LOG2_LINE][LINE_SIZE-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld  <= '0;
            r_excl <= '0;
            for (int k = 0; k < LOG2_LINE; k++) begin
                for (int j = 0; j < LINE_SIZE; j++) begin
                    r_sum[k][j] <= '0;
                end
            end
        end else begin
            if (flush) begin
                r_vld <= '0;
            end else if (w_advance) begin
                r_vld <= w_vld[LOG2_LINE-1:0];
            end
            // Data loads freely on advance; invalid slots simply carry junk.
            if (w_advance) begin
                r_excl <= w_excl[LOG2_LINE-1:0];
                for (int k = 0; k < LOG2_LINE; k++) begin
                    for (int j = 0; j < LINE_SIZE; j++) begin
                        r_sum[k][j] <= w_next[k][j];
                    end
                end
            end
        end
    end

`ifdef ZVPS_OUT_REG_EN
    logic                           r_out_valid;
    logic [LINE_SIZE*IDX_WIDTH-1:0] r_out_psum;
    logic [IDX_WIDTH-1:0]           r_out_total;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_psum  <= '0;
            r_out_total <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_advance) begin
                r_out_valid <= w_vld[LOG2_LINE];
            end
            if (w_advance) begin
                r_out_psum  <= w_psum;
                r_out_total <= w_total;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_psum  = r_out_psum;
    assign out_total = r_out_total;
`else
    assign out_valid = w_vld[LOG2_LINE];
    assign out_psum  = w_psum;
    assign out_total = w_total;
`endif

endmodule
`default_nettype wire

// File: tb/tb_zv_prefix_sum_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_zv_prefix_sum_pipe
// Description : Self-checking bench for zv_prefix_sum_pipe (LINE_SIZE=32).
//               Directed vector table plus stall, flush and async-reset
//               sequences. Honours ZVPS_OUT_REG_EN for expected latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zv_prefix_sum_pipe;

    localparam int LS = 32;
    localparam int IW = 6;
    localparam int PW = LS * IW;
`ifdef ZVPS_OUT_REG_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LS-1:0] in_mask = '0;
    logic          in_excl = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_psum;
    logic [IW-1:0] out_total;

    int checks   = 0;
    int failures = 0;

    zv_prefix_sum_pipe #(.LINE_SIZE(LS)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .in_excl   (in_excl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_psum  (out_psum),
        .out_total (out_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   mask;
        logic          excl;
        logic [IW-1:0] total;
        logic [IW-1:0] l0;
        logic [IW-1:0] l5;
        logic [IW-1:0] l31;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serial running-sum reference.
    function automatic logic [PW-1:0] ref_psum(input logic [31:0] m, input logic e);
        logic [PW-1:0] r;
        int acc;
        r   = '0;
        acc = 0;
        for (int i = 0; i < LS; i++) begin
            if (e) begin
                r[i*IW +: IW] = IW'(acc);
                acc += int'(m[i]);
            end else begin
                acc += int'(m[i]);
                r[i*IW +: IW] = IW'(acc);
            end
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] ref_total(input logic [31:0] m);
        int acc;
        acc = 0;
        for (int i = 0; i < LS; i++) acc += int'(m[i]);
        return IW'(acc);
    endfunction

    function automatic logic [IW-1:0] lane(input logic [PW-1:0] p, input int i);
        return p[i*IW +: IW];
    endfunction

    // Single vector into an empty pipe; checks acceptance, latency and result.
    task automatic run_one(input logic [31:0] m, input logic e, input string tag,
                           output logic [PW-1:0] p, output logic [IW-1:0] t);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_mask = m; in_excl = e; out_ready = 1'b1;
        #1;
        chk({tag, " in_ready"}, PW'(in_ready), PW'(1));
        @(negedge clk);
        in_valid = 1'b0; in_mask = '0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, PW'(n), PW'(LAT));
        p = out_psum;
        t = out_total;
        chk({tag, " psum"}, p, ref_psum(m, e));
        chk({tag, " total"}, PW'(t), PW'(ref_total(m)));
        @(negedge clk);
    endtask

    initial begin
        logic [PW-1:0] p;
        logic [IW-1:0] t;
        logic [32:0]   q [$];
        int sent, got, fo, stalls, extra, cnt;

        tbl[0] = '{32'hFFFF_FFFF, 1'b0, 6'd32, 6'd1, 6'd6, 6'd32};
        tbl[1] = '{32'hFFFF_FFFF, 1'b1, 6'd32, 6'd0, 6'd5, 6'd31};
        tbl[2] = '{32'h5555_5555, 1'b0, 6'd16, 6'd1, 6'd3, 6'd16};
        tbl[3] = '{32'h8000_0000, 1'b1, 6'd1,  6'd0, 6'd0, 6'd0};
        tbl[4] = '{32'h8000_0000, 1'b0, 6'd1,  6'd0, 6'd0, 6'd1};
        tbl[5] = '{32'h0000_0001, 1'b0, 6'd1,  6'd1, 6'd1, 6'd1};
        tbl[6] = '{32'h0000_000F, 1'b1, 6'd4,  6'd0, 6'd4, 6'd4};
        tbl[7] = '{32'hAAAA_AAAA, 1'b0, 6'd16, 6'd0, 6'd3, 6'd16};

        // Reset state
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst out_valid", PW'(out_valid), PW'(0));
        chk("rst out_psum", out_psum, '0);
        chk("rst out_total", PW'(out_total), PW'(0));
        chk("rst in_ready", PW'(in_ready), PW'(1));
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_one(tbl[i].mask, tbl[i].excl, $sformatf("vec%0d", i), p, t);
            chk($sformatf("vec%0d lane0", i),  PW'(lane(p, 0)),  PW'(tbl[i].l0));
            chk($sformatf("vec%0d lane5", i),  PW'(lane(p, 5)),  PW'(tbl[i].l5));
            chk($sformatf("vec%0d lane31", i), PW'(lane(p, 31)), PW'(tbl[i].l31));
            chk($sformatf("vec%0d tot", i),    PW'(t),           PW'(tbl[i].total));
        end

        // Back-to-back stream with a 4-cycle downstream stall
        sent = 0; got = 0; fo = -1; stalls = 0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            @(negedge clk);
            if (fo < 0 && out_valid) fo = cyc;
            out_ready = !(fo >= 0 && cyc - fo >= 3 && cyc - fo <= 6);
            if (sent < 8) begin
                in_valid = 1'b1; in_mask = 32'(sent + 1); in_excl = sent[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                chk("stall in_ready", PW'(in_ready), PW'(0));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("stream unexpected out", PW'(1), PW'(0));
                end else begin
                    chk($sformatf("stream psum #%0d", got), out_psum, ref_psum(q[0][31:0], q[0][32]));
                    chk($sformatf("stream total #%0d", got), PW'(out_total), PW'(ref_total(q[0][31:0])));
                    if (out_ready) begin
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back({in_excl, in_mask});
                sent++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream received", PW'(got), PW'(8));
        chk("stream sent", PW'(sent), PW'(8));
        chk("stall cycles", PW'(stalls), PW'(4));
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("stream duplicates", PW'(extra), PW'(0));

        // Flush with three vectors in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_mask = 32'h0000_FFFF; in_excl = 1'b0; out_ready = 1'b1;
        end
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_mask = 32'h3;
        #1;
        chk("flush in_ready", PW'(in_ready), PW'(0));
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("flush survivors", PW'(extra), PW'(0));
        run_one(32'h1, 1'b0, "post-flush", p, t);
        chk("post-flush lane17", PW'(lane(p, 17)), PW'(1));
        chk("post-flush tot", PW'(t), PW'(1));

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_mask = 32'hFFFF_FFFF; in_excl = 1'b0; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("pre-reset out_valid", PW'(out_valid), PW'(1));
        #2 reset = 1'b1;
        #1;
        chk("async rst out_valid", PW'(out_valid), PW'(0));
        chk("async rst out_psum", out_psum, '0);
        chk("async rst out_total", PW'(out_total), PW'(0));
        chk("async rst in_ready", PW'(in_ready), PW'(1));
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("post-reset stale", PW'(extra), PW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
